// File: rtl/fetch_buf_pkg.sv
//------------------------------------------------------------------------------
// Module  : fetch_buf_pkg
// Brief   : Shared widths and helpers for the instruction prefetch queue.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_buf_pkg;

  // Bytes per instruction word; fetch_pc advances by this much per fetch.
  localparam int C_INST_BYTES = 4;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module  : fetch_fifo
// Brief   : Synchronous {pc, inst} FIFO with flush, push/pop, count and head peek.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import fetch_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  output logic [PC_W-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [CNT_W-1:0]  count
);

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_pc_mem[r_wr_ptr]   <= push_pc;
      r_inst_mem[r_wr_ptr] <= push_inst;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (push && !pop)      r_count <= r_count + CNT_W'(1);
      else if (pop && !push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign head_pc   = r_pc_mem[r_rd_ptr];
  assign head_inst = r_inst_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_buf.sv
//------------------------------------------------------------------------------
// Module  : fetch_buf
// Brief   : Instruction prefetch queue between ROM and if_id, with jump flush
//           and optional zero-latency bypass when the queue is empty.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INST_W   = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit               BYPASS   = 1'b1,
  localparam int              CNT_W    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              id_ready,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] C_STEP  = ADDR_W'(C_INST_BYTES);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_head_pc;
  logic [INST_W-1:0] w_head_inst;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_valid;
  logic              w_pop;
  logic              w_fetch;
  logic              w_bypass_take;
  logic              w_push;
  logic              w_fifo_pop;
  logic              w_unused;

  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == C_DEPTH);

  // Empty queue never blocks a fetch, so valid does not depend on fetch.
  assign w_valid       = !jump_flag && (!w_empty || BYPASS);
  assign w_pop         = w_valid && id_ready;
  assign w_fetch       = !jump_flag && (!w_full || w_pop);
  assign w_bypass_take = w_pop && w_empty;
  assign w_push        = w_fetch && !w_bypass_take;
  assign w_fifo_pop    = w_pop && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (jump_flag) begin
      r_fetch_pc <= {jump_addr[ADDR_W-1:2], 2'b00};
    end else if (w_fetch) begin
      r_fetch_pc <= r_fetch_pc + C_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .PC_W   (ADDR_W),
    .INST_W (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_flag),
    .push      (w_push),
    .push_pc   (r_fetch_pc),
    .push_inst (rom_inst),
    .pop       (w_fifo_pop),
    .head_pc   (w_head_pc),
    .head_inst (w_head_inst),
    .count     (w_count)
  );

  // Outputs are gated by rst so they drop immediately, without a clock edge.
  assign rom_ce    = rst && w_fetch;
  assign rom_addr  = r_fetch_pc;
  assign out_valid = rst && w_valid;
  assign out_pc    = out_valid ? (w_empty ? r_fetch_pc : w_head_pc) : '0;
  assign out_inst  = out_valid ? (w_empty ? rom_inst : w_head_inst) : '0;
  assign count     = w_count;

  assign w_unused = ^jump_addr[1:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_buf.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_buf
// Brief   : Randomised bench for fetch_buf, BYPASS=1 and BYPASS=0 side by side
//           against a queue-based reference model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        id_ready;

  logic        ce    [2];
  logic        ov    [2];
  logic [31:0] raddr [2];
  logic [31:0] rinst [2];
  logic [31:0] opc   [2];
  logic [31:0] oinst [2];
  logic [2:0]  cnt   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: PCs waiting in the queue, plus the next fetch address.
  logic [31:0] mq   [2][$];
  logic [31:0] mfpc [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A00_0000;
  endfunction

  assign rinst[0] = rom_fn(raddr[0]);
  assign rinst[1] = rom_fn(raddr[1]);

  fetch_buf #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .BYPASS(1'b1)
  ) dut_byp (
    .clk(clk), .rst(rst_n), .jump_flag(jump_flag), .jump_addr(jump_addr),
    .id_ready(id_ready), .rom_ce(ce[0]), .rom_addr(raddr[0]), .rom_inst(rinst[0]),
    .out_valid(ov[0]), .out_pc(opc[0]), .out_inst(oinst[0]), .count(cnt[0])
  );

  fetch_buf #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .BYPASS(1'b0)
  ) dut_reg (
    .clk(clk), .rst(rst_n), .jump_flag(jump_flag), .jump_addr(jump_addr),
    .id_ready(id_ready), .rom_ce(ce[1]), .rom_addr(raddr[1]), .rom_inst(rinst[1]),
    .out_valid(ov[1]), .out_pc(opc[1]), .out_inst(oinst[1]), .count(cnt[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mq[b].delete();
      mfpc[b] = RESET_PC;
    end
  endtask

  // Compare one DUT against the model for the current cycle, then advance the model.
  task automatic model_step(input int b);
    logic        byp, exp_valid, pop, fetch, take;
    logic [31:0] exp_pc;
    int          sz;
    string       nm;
    nm  = (b == 0) ? "byp" : "reg";
    byp = (b == 0);
    sz  = mq[b].size();
    if (!rst_n) begin
      check({nm, " rst valid"}, 64'(ov[b]), 64'(0));
      check({nm, " rst ce"},    64'(ce[b]), 64'(0));
      check({nm, " rst pc"},    64'(opc[b]), 64'(0));
      check({nm, " rst inst"},  64'(oinst[b]), 64'(0));
      check({nm, " rst count"}, 64'(cnt[b]), 64'(0));
      check({nm, " rst addr"},  64'(raddr[b]), 64'(RESET_PC));
      return;
    end
    exp_valid = !jump_flag && (sz > 0 || byp);
    exp_pc    = (sz > 0) ? mq[b][0] : mfpc[b];
    pop       = exp_valid && id_ready;
    fetch     = !jump_flag && (sz < DEPTH || pop);
    check({nm, " valid"}, 64'(ov[b]), 64'(exp_valid));
    check({nm, " ce"},    64'(ce[b]), 64'(fetch));
    check({nm, " addr"},  64'(raddr[b]), 64'(mfpc[b]));
    check({nm, " count"}, 64'(cnt[b]), 64'(sz));
    if (exp_valid) begin
      check({nm, " pc"},   64'(opc[b]), 64'(exp_pc));
      check({nm, " inst"}, 64'(oinst[b]), 64'(rom_fn(exp_pc)));
    end
    if (jump_flag) begin
      mq[b].delete();
      mfpc[b] = {jump_addr[31:2], 2'b00};
    end else begin
      take = pop && (sz == 0);
      if (pop && sz > 0) void'(mq[b].pop_front());
      if (fetch && !take) mq[b].push_back(mfpc[b]);
      if (fetch) mfpc[b] = mfpc[b] + 32'd4;
    end
  endtask

  task automatic cycle(input logic jf, input logic [31:0] ja, input logic ir);
    @(negedge clk);
    jump_flag = jf;
    jump_addr = ja;
    id_ready  = ir;
    #2;
    model_step(0);
    model_step(1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    jump_flag = 1'b0;
    jump_addr = '0;
    id_ready  = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Free-running decode from reset
    cycle(1'b0, 32'h0, 1'b1);
    check("s1 first valid byp", 64'(ov[0]), 64'(1));
    check("s1 first pc byp", 64'(opc[0]), 64'(RESET_PC));
    check("s1 first valid reg", 64'(ov[1]), 64'(0));
    repeat (8) cycle(1'b0, 32'h0, 1'b1);
    check("s1 count byp", 64'(cnt[0]), 64'(0));

    // Hold the decoder until the queue fills, then drain
    apply_reset();
    repeat (11) cycle(1'b0, 32'h0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      check("s2 full count", 64'(cnt[b]), 64'(DEPTH));
      check("s2 full ce", 64'(ce[b]), 64'(0));
      check("s2 full addr", 64'(raddr[b]), 64'(32'h10));
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check("s2 drain pc", 64'(opc[0]), 64'(32'(i * 4)));
    end

    // Jump while full
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h103, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    for (int b = 0; b < 2; b++) begin
      check("s3 jump count", 64'(cnt[b]), 64'(0));
      check("s3 jump addr", 64'(raddr[b]), 64'(32'h100));
    end
    check("s3 jump pc byp", 64'(opc[0]), 64'(32'h100));
    repeat (4) cycle(1'b0, 32'h0, 1'b1);

    // Jump while held, then back-to-back jumps
    repeat (2) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h200, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("s4 held jump pc byp", 64'(opc[0]), 64'(32'h200));
    check("s4 held jump pc reg", 64'(opc[1]), 64'(32'h200));
    cycle(1'b1, 32'h300, 1'b1);
    cycle(1'b1, 32'h446, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("s4 last jump wins", 64'(raddr[0]), 64'(32'h444));
    repeat (4) cycle(1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream with three entries queued
    apply_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    jump_flag = 1'b0;
    id_ready  = 1'b0;
    #1;
    check("s5 count byp", 64'(cnt[0]), 64'(3));
    check("s5 count reg", 64'(cnt[1]), 64'(3));
    rst_n = 1'b0;
    #1;
    for (int b = 0; b < 2; b++) begin
      check("s5 async valid", 64'(ov[b]), 64'(0));
      check("s5 async ce", 64'(ce[b]), 64'(0));
      check("s5 async count", 64'(cnt[b]), 64'(0));
    end
    model_reset();
    cycle(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    check("s5 restart addr", 64'(raddr[0]), 64'(RESET_PC));
    repeat (4) cycle(1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) == 0), 32'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_buf.md
Name: fetch_buf

Overview:
- Parametrised instruction prefetch queue between the instruction ROM and the if_id stage register of the xcore pipeline.
- Runs ahead of the decoder, fetching sequential words while the pipeline is held.
- Flushes and redirects on a jump request from ctrl.
- Replaces the single-register PC/fetch path; optional empty-queue bypass gives zero-latency fetch when the queue is drained.

Parameters:
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction word width
- DEPTH, 4, queue entries; power of two, at least 2
- RESET_PC, 32'h0, first fetch address after reset
- BYPASS, 1, 1 = empty queue forwards the ROM word combinationally; 0 = always registered

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous and active-low
- jump_flag  in  1  redirect request from ctrl
- jump_addr  in  ADDR_W  redirect target; bits [1:0] ignored, forced to 0
- id_ready  in  1  downstream accepts the output entry this cycle (not held)
- rom_ce  out  1  ROM enable; a fetch occurs this cycle
- rom_addr  out  ADDR_W  ROM address, equals fetch_pc
- rom_inst  in  INST_W  ROM data, combinational from rom_addr in the same cycle
- out_valid  out  1  out_pc/out_inst hold a valid instruction
- out_pc  out  ADDR_W  PC of the head instruction
- out_inst  out  INST_W  head instruction word
- count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = RESET_PC; queue emptied (count = 0); rd/wr pointers = 0.
  - rom_ce = 0; out_valid = 0; out_pc = 0; out_inst = 0. All outputs hold these values while rst is low.
- Entries: storage arrays of {pc, inst}, DEPTH deep; pointers wrap modulo DEPTH.
- pop = out_valid && id_ready && !jump_flag.
- Fetch, normal cycle (no jump):
  - fetch = (count < DEPTH) || pop.
  - rom_ce = fetch; rom_addr = fetch_pc always.
  - On fetch: {fetch_pc, rom_inst} is pushed at the clock edge and fetch_pc += 4 (wraps at 2^ADDR_W).
  - Full with no pop: rom_ce = 0, fetch_pc holds. No push is ever dropped.
- Output with count > 0: out_valid = 1; out_pc/out_inst = entry at the read pointer (registered).
- Output with count == 0:
  - BYPASS = 1: out_valid = fetch; out_pc = fetch_pc; out_inst = rom_inst. If popped in the same cycle, the word is consumed and not pushed (count stays 0).
  - BYPASS = 0: out_valid = 0.
- count update: +1 on push without pop, -1 on pop without push, unchanged on both or neither. Push and pop in the same cycle with count == DEPTH is legal.
- Jump (jump_flag = 1), highest priority:
  - That cycle: rom_ce = 0; out_valid forced 0; no pop, no push.
  - At the edge: queue flushed (count = 0, pointers = 0); fetch_pc = {jump_addr[ADDR_W-1:2], 2'b00}.
  - The first target word is visible at the output the cycle after the jump (BYPASS = 1), or two cycles after (BYPASS = 0).
- Jump while id_ready = 0, or while the queue is full: same as above. The flush takes effect regardless of hold.
- Consecutive jump cycles: the last jump_addr wins.
- No sequential state outside the queue, fetch_pc and pointers. The block has no FSM beyond the RESET → RUN transition on rst release. The first cycle after release fetches RESET_PC.

Decomposition:
- Shared defines (existing defines.v): InstAddrBus, InstBus, and a new FetchCntBus width macro derived from DEPTH.
- One natural sub-module: fetch_fifo, a parametrised synchronous FIFO with flush, push/pop, count and head peek.
- The fetch_buf top holds fetch_pc, the fetch/pop arbitration and the bypass mux.

Test Plan:
- Reset release, id_ready = 1, BYPASS = 1, ROM mem[i] = i: out_valid in the first cycle; out_pc 0, 4, 8… one per cycle; count stays 0.
- id_ready = 0 for 10 cycles after release, DEPTH = 4: count rises 1..4 then holds; rom_ce = 0 once full; fetch_pc = 0x10; on id_ready = 1, outputs 0, 4, 8, C, 10 on consecutive cycles without a gap.
- Full queue and jump_flag = 1 with jump_addr = 0x103: next cycle count = 0, rom_addr = 0x100; out_pc = 0x100 on the following output cycle; stale entries never appear.
- Jump while id_ready = 0: flush still occurs; after id_ready rises, the first out_pc equals the jump target.
- BYPASS = 0 regression of the first scenario: first out_valid one cycle after release; out_pc sequence identical.
- rst asserted mid-stream with count = 3: out_valid and rom_ce drop immediately (no clock edge needed); after release the fetch restarts at RESET_PC.
